// File: rtl/circuit_2_pkg.sv
// Shared constants for the scheduled circuit_2 datapath: FSM state encoding
// and opcodes for the shared add/sub unit.
package circuit_2_pkg;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ADD1    = 3'd1;
  localparam logic [2:0] S_ADD2    = 3'd2;
  localparam logic [2:0] S_SUB_CMP = 3'd3;
  localparam logic [2:0] S_SEL     = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/circuit_2_fsmd_if.sv
// Start/done handshake plus operand and result bus of circuit_2_fsmd.
interface circuit_2_fsmd_if #(
  parameter int DATAWIDTH = 8
);

  logic                 Start;
  logic [DATAWIDTH-1:0] a;
  logic [DATAWIDTH-1:0] b;
  logic [DATAWIDTH-1:0] c;
  logic                 Busy;
  logic                 Done;
  logic [DATAWIDTH-1:0] x;
  logic [DATAWIDTH-1:0] z;

  modport master (output Start, a, b, c, input Busy, Done, x, z);
  modport slave  (input Start, a, b, c, output Busy, Done, x, z);

endinterface

// File: rtl/circuit_2_fsmd_addsub_unit.sv
// Shared combinational adder/subtractor, modulo 2^DATAWIDTH.
module addsub_unit
  import circuit_2_pkg::*;
#(
  parameter int DATAWIDTH = 8
) (
  input  logic                 op,
  input  logic [DATAWIDTH-1:0] p,
  input  logic [DATAWIDTH-1:0] q,
  output logic [DATAWIDTH-1:0] r
);

  assign r = (op == OP_SUB) ? (p - q) : (p + q);

endmodule

// File: rtl/circuit_2_fsmd.sv
// Multi-cycle circuit_2: one shared add/sub unit and one comparator scheduled
// over ADD1/ADD2/SUB_CMP, results selected and shifted in SEL.
module circuit_2_fsmd
  import circuit_2_pkg::*;
#(
  parameter int DATAWIDTH = 8
) (
  input  logic              Clk,
  input  logic              Rst,
  circuit_2_fsmd_if.slave   bus
);

  logic [2:0]           state_q, state_d;
  logic [DATAWIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic [DATAWIDTH-1:0] d_q, d_d, e_q, e_d, f_q, f_d;
  logic                 lt_q, lt_d, eq_q, eq_d;
  logic [DATAWIDTH-1:0] x_q, x_d, z_q, z_d;

  logic                 alu_op;
  logic [DATAWIDTH-1:0] alu_q, alu_r;
  logic [DATAWIDTH-1:0] g, h;

  addsub_unit #(.DATAWIDTH(DATAWIDTH)) u_addsub (
    .op (alu_op),
    .p  (a_q),
    .q  (alu_q),
    .r  (alu_r)
  );

  // Selection works on the registered compare flags from SUB_CMP.
  assign g = lt_q ? d_q : e_q;
  assign h = eq_q ? g : f_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    d_d     = d_q;
    e_d     = e_q;
    f_d     = f_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    x_d     = x_q;
    z_d     = z_q;
    alu_op  = OP_ADD;
    alu_q   = b_q;

    case (state_q)
      S_IDLE: begin
        if (bus.Start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          c_d     = bus.c;
          state_d = S_ADD1;
        end
      end
      S_ADD1: begin
        d_d     = alu_r;
        state_d = S_ADD2;
      end
      S_ADD2: begin
        alu_q   = c_q;
        e_d     = alu_r;
        state_d = S_SUB_CMP;
      end
      S_SUB_CMP: begin
        alu_op  = OP_SUB;
        f_d     = alu_r;
        lt_d    = (d_q < e_q);
        eq_d    = (d_q == e_q);
        state_d = S_SEL;
      end
      S_SEL: begin
        // Left shift drops the MSB; right shift zero-fills.
        x_d     = g << lt_q;
        z_d     = h >> eq_q;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      e_q     <= '0;
      f_q     <= '0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
      x_q     <= '0;
      z_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      d_q     <= d_d;
      e_q     <= e_d;
      f_q     <= f_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
      x_q     <= x_d;
      z_q     <= z_d;
    end
  end

  assign bus.Busy = (state_q != S_IDLE);
  assign bus.Done = (state_q == S_DONE);
  assign bus.x    = x_q;
  assign bus.z    = z_q;

endmodule

// File: doc/circuit_2_fsmd.md
Name: circuit_2_fsmd

Overview:
- Multi-cycle, resource-shared implementation of the circuit_2 dataflow: d=a+b, e=a+c, f=a-b, then compare, select and shift.
- Paired control-FSM and datapath behind a start/done handshake. One shared add/sub unit and one comparator replace the three parallel arithmetic units.
- Sits beside the fully parallel circuit_2 in the HLS flow as the scheduled, area-reduced counterpart.
- Outputs are bit-identical to the parallel version's function.

Parameters:
- DATAWIDTH, 8, width of a, b, c, all intermediates and x, z.

Ports:
- Clk  input  1  rising-edge clock.
- Rst  input  1  synchronous, active-low reset (Rst=0 sampled at a Clk edge resets).
- Start  input  1  request; sampled only in IDLE.
- a  input  DATAWIDTH  operand; latched on accepted Start.
- b  input  DATAWIDTH  operand; latched on accepted Start.
- c  input  DATAWIDTH  operand; latched on accepted Start.
- Busy  output  1  high whenever state != IDLE.
- Done  output  1  one-cycle pulse; x and z valid during it.
- x  output  DATAWIDTH  registered result g << dLTe.
- z  output  DATAWIDTH  registered result h >> dEQe.

Behaviour:
- Function (all unsigned, modulo 2^DATAWIDTH):
  - d=a+b, e=a+c, f=a-b.
  - dLTe=(d<e), dEQe=(d==e).
  - g = dLTe ? d : e.
  - h = dEQe ? g : f.
  - x = g<<dLTe (0 or 1 bit, MSB discarded), z = h>>dEQe (logical, zero fill).
- States: IDLE, ADD1, ADD2, SUB_CMP, SEL, DONE.
- Transitions:
  - IDLE->ADD1 when Start=1; latch a, b, c into internal registers.
  - Otherwise stay in IDLE.
  - ADD1->ADD2->SUB_CMP->SEL->DONE->IDLE unconditionally.
- Per-state work:
  - ADD1: shared unit adds, d_reg <= a_r+b_r.
  - ADD2: shared unit adds, e_reg <= a_r+c_r.
  - SUB_CMP: shared unit subtracts, f_reg <= a_r-b_r; comparator registers lt_reg and eq_reg from d_reg and e_reg.
  - SEL: compute g, h and shifts combinationally; x and z load at the end of SEL.
- Latency: Start high in cycle T (IDLE) gives Done=1 in cycle T+5; Busy=1 in cycles T+1..T+5.
- Throughput: one result per 6 cycles. Earliest next accept is in cycle T+6 (IDLE).
- Start outside IDLE is ignored and not queued. Operand changes after acceptance have no effect.
- x and z hold their last values until the next SEL edge. They do not change in IDLE or DONE.
- Done is registered: 1 only in DONE, 0 elsewhere.
- Reset values: state=IDLE, Busy=0, Done=0, x=0, z=0, all internal registers 0.
- Reset mid-operation aborts the computation. The next cycle is IDLE, x and z read 0, and no Done is emitted.
- Rst=0 and Start=1 at the same edge: reset wins, no accept.

Decomposition:
- Shared package circuit_2_pkg holds:
  - state encoding constants (3-bit, binary: IDLE=0 .. DONE=5);
  - ALU opcode constants OP_ADD=0, OP_SUB=1.
- One sub-module, addsub_unit(DATAWIDTH): inputs op, p, q; output r = op ? p-q : p+q. Purely combinational, instantiated once.
- Comparator, muxes and shifters stay inline in the top module.

Test Plan (DATAWIDTH=8; check x, z in the Done cycle):
- a=10, b=3, c=5, Start 1 cycle -> Busy for 5 cycles, Done at T+5, x=26, z=7.
- Equal case a=4, b=6, c=6 -> d=e=10, f=254, x=10, z=5.
- Greater case a=20, b=9, c=1 -> x=21, z=11.
- Overflow a=150, b=50, c=100 -> d=200, e=250, x=144 (shift drops MSB), z=100.
  - Also a=200, b=100, c=50 -> d wraps to 44, x=88, z=100.
- Start held high continuously with operands changing every cycle -> accepts only at T and T+6. Each result matches the operands latched at its accept; Done pulses exactly once per run.
- Rst=0 during SUB_CMP of a run -> next cycle IDLE, Busy=0, x=z=0, no Done.
  - A fresh Start afterwards completes normally with the correct result.
